// File: rtl/alu_pkg.sv
// Shared ALU select encodings and arbiter FSM states.
// Encoding is {funct7[5], funct3}; 4'b1111 passes rs2 straight through.
package alu_pkg;

  typedef logic [3:0] alu_sel_t;

  localparam alu_sel_t ALU_ADD    = 4'b0000;
  localparam alu_sel_t ALU_SUB    = 4'b1000;
  localparam alu_sel_t ALU_SLL    = 4'b0001;
  localparam alu_sel_t ALU_SLT    = 4'b0010;
  localparam alu_sel_t ALU_SLTU   = 4'b0011;
  localparam alu_sel_t ALU_XOR    = 4'b0100;
  localparam alu_sel_t ALU_SRL    = 4'b0101;
  localparam alu_sel_t ALU_SRA    = 4'b1101;
  localparam alu_sel_t ALU_OR     = 4'b0110;
  localparam alu_sel_t ALU_AND    = 4'b0111;
  localparam alu_sel_t ALU_PASS_B = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle 32-bit integer ALU.
// Latency: combinational, 0 cycles.
// Backpressure: none; output follows inputs.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  alusel,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (alu_sel_t'(alusel))
      ALU_ADD:    result = rs1 + rs2;
      ALU_SUB:    result = rs1 - rs2;
      ALU_SLL:    result = rs1 << rs2[4:0];
      ALU_SLT:    result = {31'b0, $signed(rs1) < $signed(rs2)};
      ALU_SLTU:   result = {31'b0, rs1 < rs2};
      ALU_XOR:    result = rs1 ^ rs2;
      ALU_SRL:    result = rs1 >> rs2[4:0];
      ALU_SRA:    result = $unsigned($signed(rs1) >>> rs2[4:0]);
      ALU_OR:     result = rs1 | rs2;
      ALU_AND:    result = rs1 & rs2;
      ALU_PASS_B: result = rs2;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Latency: combinational, 0 cycles.
// Backpressure: none; grant follows req/ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  int               pos;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    pos       = 0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Modulo done by subtraction so non power-of-two NUM_REQ wraps correctly.
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = IDX_W'(pos);
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin shares one ALU among NUM_REQ requesters, one op in flight.
// Latency: request handshake in cycle N -> rsp_valid_o in cycle N+2.
// Backpressure: result held until owner's rsp_ready_i; req_ready_o low while busy.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*XLEN-1:0] req_rs1_i,
  input  logic [NUM_REQ*XLEN-1:0] req_rs2_i,
  input  logic [NUM_REQ*4-1:0]    req_alusel_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  input  logic [NUM_REQ-1:0]      rsp_ready_i,
  output logic [XLEN-1:0]         rsp_result_o,
  output logic                    busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] owner_q;
  logic [XLEN-1:0]  rs1_q, rs2_q;
  alu_sel_t         sel_q;
  logic [XLEN-1:0]  result_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic               load;
  logic [31:0]        alu_result;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid_i),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  alu u_alu (
    .alusel (sel_q),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .result (alu_result)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is a pure function of valid here, so ready implies handshake.
        if (!rst_i && grant_vld) begin
          req_ready_o = grant;
          load        = 1'b1;
          state_d     = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        if (rsp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      sel_q    <= ALU_ADD;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        owner_q <= grant_idx;
        rs1_q   <= req_rs1_i[grant_idx*XLEN +: XLEN];
        rs2_q   <= req_rs2_i[grant_idx*XLEN +: XLEN];
        sel_q   <= alu_sel_t'(req_alusel_i[grant_idx*4 +: 4]);
        ptr_q   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state_q == EXEC) result_q <= alu_result;
    end
  end

  assign rsp_result_o = result_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter with two requesters.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_rs1;
  logic [63:0] req_rs2;
  logic [7:0]  req_alusel;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_rs1_i    (req_rs1),
    .req_rs2_i    (req_rs2),
    .req_alusel_i (req_alusel),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; checks land 4ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic vld, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] s);
    req_valid[idx]         = vld;
    req_rs1[idx*32 +: 32]  = a;
    req_rs2[idx*32 +: 32]  = b;
    req_alusel[idx*4 +: 4] = s;
  endtask

  task automatic do_op(input string tag, input int idx, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] s, input logic [31:0] exp);
    logic [1:0] oh;
    oh = 2'b01 << idx;
    set_req(idx, 1'b1, a, b, s);
    #3;
    chk({tag, "_rdy"}, {30'b0, req_ready}, {30'b0, oh});
    chk({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
    step();
    set_req(idx, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0000);
    #3;
    chk({tag, "_busy_exec"}, {31'b0, busy}, 32'd1);
    chk({tag, "_vld_exec"}, {30'b0, rsp_valid}, 32'd0);
    step();
    #3;
    chk({tag, "_vld"}, {30'b0, rsp_valid}, {30'b0, oh});
    chk({tag, "_res"}, rsp_result, exp);
    chk({tag, "_busy_resp"}, {31'b0, busy}, 32'd1);
    step();
    #3;
    chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    step();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_alusel = '0;
    rsp_ready  = 2'b11;
    step();
    step();
    #3;
    chk("rst_rdy", {30'b0, req_ready}, 32'd0);
    chk("rst_vld", {30'b0, rsp_valid}, 32'd0);
    chk("rst_res", rsp_result, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Single op and edge-case ALU results
    do_op("add", 0, 32'd5, 32'd3, 4'b0000, 32'd8);
    do_op("sltu", 0, 32'hFFFF_FFFF, 32'd1, 4'b0011, 32'd0);
    do_op("slt", 0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1);
    do_op("add_wrap", 1, 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0);
    do_op("pass_b", 0, 32'h1234_5678, 32'hABCD_0000, 4'b1111, 32'hABCD_0000);
    do_op("undef", 1, 32'h1234_5678, 32'h0000_0003, 4'b1010, 32'd0);
    do_op("srl", 0, 32'h8000_0000, 32'd36, 4'b0101, 32'h0800_0000);
    do_op("xor", 1, 32'h0000_F0F0, 32'h0000_FF00, 4'b0100, 32'h0000_0FF0);

    // Operand isolation: inputs scrambled right after handshake
    set_req(0, 1'b1, 32'd7, 32'd1, 4'b0000);
    #3;
    chk("iso_rdy", {30'b0, req_ready}, 32'd1);
    step();
    set_req(0, 1'b0, 32'd100, 32'd50, 4'b1000);
    step();
    #3;
    chk("iso_vld", {30'b0, rsp_valid}, 32'd1);
    chk("iso_res", rsp_result, 32'd8);
    step();
    step();

    // Reset during EXEC; req0 grant would otherwise move pointer to 1
    set_req(0, 1'b1, 32'd9, 32'd9, 4'b0000);
    #3;
    chk("rmid_rdy", {30'b0, req_ready}, 32'd1);
    step();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'b0000);
    rst = 1'b1;
    #3;
    chk("rmid_busy_exec", {31'b0, busy}, 32'd1);
    step();
    rst = 1'b0;
    #3;
    chk("rmid_vld", {30'b0, rsp_valid}, 32'd0);
    chk("rmid_busy", {31'b0, busy}, 32'd0);
    chk("rmid_res", rsp_result, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      #3;
      chk("rmid_stale", {30'b0, rsp_valid}, 32'd0);
    end
    step();
    set_req(0, 1'b1, 32'd1, 32'd1, 4'b0000);
    set_req(1, 1'b1, 32'd1, 32'd1, 4'b0000);
    #3;
    chk("rmid_ptr0", {30'b0, req_ready}, 32'd1);
    req_valid = 2'b00;
    step();

    // Contention: both valid every cycle, grants alternate starting at 0
    set_req(0, 1'b1, 32'd10, 32'd4, 4'b1000);
    set_req(1, 1'b1, 32'd1, 32'd4, 4'b0001);
    for (int k = 0; k < 10; k++) begin
      #3;
      chk("cont_rdy", {30'b0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      #3;
      chk("cont_rdy_exec", {30'b0, req_ready}, 32'd0);
      step();
      #3;
      chk("cont_vld", {30'b0, rsp_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_res", rsp_result, (k % 2 == 0) ? 32'd6 : 32'd16);
      step();
    end
    req_valid = 2'b00;
    step();

    // Backpressure on owner 1 while req0 waits and rsp_ready_i[0] toggles
    set_req(1, 1'b1, 32'h8000_0000, 32'd4, 4'b1101);
    #3;
    chk("bp_rdy", {30'b0, req_ready}, 32'd2);
    step();
    set_req(1, 1'b0, 32'd0, 32'd0, 4'b0000);
    set_req(0, 1'b1, 32'd2, 32'd2, 4'b0000);
    rsp_ready = 2'b01;
    #3;
    chk("bp_rdy_exec", {30'b0, req_ready}, 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      rsp_ready = {1'b0, (i % 2 == 0)};
      #3;
      chk("bp_vld_hold", {30'b0, rsp_valid}, 32'd2);
      chk("bp_res_hold", rsp_result, 32'hF800_0000);
      chk("bp_rdy_hold", {30'b0, req_ready}, 32'd0);
      step();
    end
    rsp_ready = 2'b11;
    #3;
    chk("bp_vld_rel", {30'b0, rsp_valid}, 32'd2);
    chk("bp_rdy_rel", {30'b0, req_ready}, 32'd0);
    step();
    #3;
    chk("bp_req0_rdy", {30'b0, req_ready}, 32'd1);
    step();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'b0000);
    step();
    #3;
    chk("bp_req0_vld", {30'b0, rsp_valid}, 32'd1);
    chk("bp_req0_res", rsp_result, 32'd4);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
